read_src_fsm: RTL and testbench
===============================

// Module: read_src_fsm
// PURPOSE
//  Source-side DMA read engine. Splits one descriptor into AXI-MM INCR read bursts of up
//  to 2**AXI_LEN_W beats and pushes returned read data into the DMA data FIFO.
//  Issues a burst only when the FIFO has room for the whole burst.
//  Runs one descriptor at a time, with one burst outstanding.
//  Reports done, error, FSM state and bandwidth counters to the CSR block.
// PARAMETERS
//  DATA_W     512  AXI data width; beat size BYTES = DATA_W/8
//  ADDR_W     64   AXI byte-address width
//  LENGTH_W   24   descriptor length width, in beats
//  AXI_LEN_W  8    AXI len width; maximum burst MAXB = 2**AXI_LEN_W beats
//  SPACE_W    10   width of FIFO free-entry count
//  PERF_W     32   performance counter width
// PORTS
//  clk            in   1         clock
//  reset_n        in   1         reset
//  desc_valid     in   1         descriptor available
//  desc_ready     out  1         descriptor accepted when valid&ready
//  desc_src_addr  in   ADDR_W    source byte address, BYTES-aligned
//  desc_length    in   LENGTH_W  transfer length in beats
//  fifo_space     in   SPACE_W   free entries in data FIFO
//  fifo_wr_en     out  1         push r_data into FIFO
//  fifo_wr_data   out  DATA_W    FIFO write data
//  ar_valid       out  1         AXI AR valid
//  ar_ready       in   1         AXI AR ready
//  ar_addr        out  ADDR_W    AXI AR address
//  ar_len         out  AXI_LEN_W AXI AR len (beats-1)
//  ar_size        out  3         AXI AR size, constant clog2(BYTES)
//  ar_burst       out  2         AXI AR burst, constant INCR (2'b01)
//  r_valid        in   1         AXI R valid
//  r_ready        out  1         AXI R ready
//  r_data         in   DATA_W    AXI R data
//  r_resp         in   2         AXI R response; OKAY=0, SLVERR=2, DECERR=3
//  r_last         in   1         AXI R last
//  rd_done        out  1         1-cycle pulse, descriptor complete
//  rd_err         out  1         high while in ERROR
//  err_clear      in   1         leave ERROR
//  rd_state       out  5         one-hot state, for CSR status
//  rd_clk_cnt     out  PERF_W    busy cycles of last/current descriptor
//  rd_valid_cnt   out  PERF_W    R handshakes of last/current descriptor
// BEHAVIOUR
//  Clock and reset: clk, sync active-low reset_n.
//  On reset: state=IDLE; every output 0 except ar_size/ar_burst, which are constant.
//  Reset mid-transfer abandons the transfer; no AXI cleanup is performed.
//  Registers: addr, remaining beats `rem`.
//  - rem is loaded from desc_length at descriptor accept (desc_valid & desc_ready).
//  - nb = min(rem, MAXB); ar_len = nb-1.
//  States (one-hot):
//  - IDLE: desc_ready=1.
//    - accept with length==0 -> DONE.
//    - accept with length>0 -> SPACE.
//  - SPACE: wait until fifo_space >= nb, then load ar_addr/ar_len -> ADDR.
//  - ADDR: ar_valid=1; ar_addr/ar_len held stable until ar_ready.
//    - On handshake: rem -= nb; addr += nb*BYTES -> DATA.
//  - DATA: r_ready=1; fifo_wr_en = r_valid & (r_resp==OKAY); fifo_wr_data = r_data (comb).
//    - Beat with r_resp != OKAY: not pushed; err_seen latched.
//    - Burst ends on the r_valid & r_last beat.
//      - err_seen -> ERROR.
//      - rem > 0  -> SPACE.
//      - rem == 0 -> DONE.
//  - DONE: rd_done=1 for exactly one cycle -> IDLE.
//  - ERROR: rd_err=1; r_ready=1 and fifo_wr_en=0 (drains stray beats).
//    - err_clear -> IDLE; err_seen cleared.
//  Arithmetic:
//  - Address arithmetic is modulo 2**ADDR_W.
//  - A burst may cross a 4KB boundary; the interconnect handles it.
//  Perf counters:
//  - Both cleared at descriptor accept.
//  - rd_clk_cnt increments every cycle outside IDLE.
//  - rd_valid_cnt increments on each r_valid & r_ready.
//  - Both hold their value in IDLE, for readback.
//  Status: rd_state reflects the registered state.
// TESTING
//  1. len=1, addr=0x1000, space=512
//     -> one AR: addr 0x1000, len 0, size 6, burst 1; one push; rd_done pulses once.
//  2. len=600, addr=0
//     -> ARs 0x0/len255, 0x4000/len255, 0x8000/len87; 600 pushes in order; one rd_done.
//  3. len=256, space=100 for 20 cycles, then 300
//     -> no ar_valid while space<256; AR issued after the rise.
//  4. ar_ready low for 10 cycles
//     -> ar_valid, ar_addr and ar_len stable throughout; single handshake.
//  5. SLVERR on beat 3 of 8
//     -> 2 pushes; rd_err=1 after last; holds until err_clear; then IDLE, desc_ready=1.
//  6. len=0 -> no AR, rd_done one cycle later. Also reset_n low mid-DATA -> IDLE, outputs 0.

Source files
------------

// File: rtl/read_src_if.sv
`default_nettype none
// ============================================================================
// Module   : read_src_if
// Purpose  : Descriptor, data-FIFO and AXI read-channel bundle for read_src_fsm.
// Revision : 1.0
// ============================================================================
interface read_src_if #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 64,
    parameter int LENGTH_W  = 24,
    parameter int AXI_LEN_W = 8,
    parameter int SPACE_W   = 10
);
    logic                 desc_valid;
    logic                 desc_ready;
    logic [ADDR_W-1:0]    desc_src_addr;
    logic [LENGTH_W-1:0]  desc_length;
    logic [SPACE_W-1:0]   fifo_space;
    logic                 fifo_wr_en;
    logic [DATA_W-1:0]    fifo_wr_data;
    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_W-1:0]    ar_addr;
    logic [AXI_LEN_W-1:0] ar_len;
    logic [2:0]           ar_size;
    logic [1:0]           ar_burst;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_W-1:0]    r_data;
    logic [1:0]           r_resp;
    logic                 r_last;

    modport master (
        input  desc_valid, desc_src_addr, desc_length, fifo_space,
               ar_ready, r_valid, r_data, r_resp, r_last,
        output desc_ready, fifo_wr_en, fifo_wr_data,
               ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready
    );

    modport slave (
        output desc_valid, desc_src_addr, desc_length, fifo_space,
               ar_ready, r_valid, r_data, r_resp, r_last,
        input  desc_ready, fifo_wr_en, fifo_wr_data,
               ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready
    );
endinterface
`default_nettype wire

// File: rtl/read_src_fsm.sv
`default_nettype none
// ============================================================================
// Module   : read_src_fsm
// Purpose  : DMA source read engine; splits a descriptor into AXI INCR bursts.
// Revision : 1.0
// ============================================================================
module read_src_fsm #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 64,
    parameter int LENGTH_W  = 24,
    parameter int AXI_LEN_W = 8,
    parameter int SPACE_W   = 10,
    parameter int PERF_W    = 32
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    read_src_if.master             bus,
    input  wire logic              i_err_clear,
    output logic                   o_rd_done,
    output logic                   o_rd_err,
    output logic [4:0]             o_rd_state,
    output logic [PERF_W-1:0]      o_rd_clk_cnt,
    output logic [PERF_W-1:0]      o_rd_valid_cnt
);
    localparam int         C_BYTES  = DATA_W / 8;
    localparam int         C_SIZE   = $clog2(C_BYTES);
    localparam int         C_MAXB   = 2 ** AXI_LEN_W;
    localparam int         C_CMP_W  = (LENGTH_W > SPACE_W) ? LENGTH_W : SPACE_W;
    localparam logic [1:0] C_INCR   = 2'b01;
    localparam logic [1:0] C_OKAY   = 2'b00;

    // IDLE is the all-zero code so the status reads 0 straight out of reset
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00000,
        S_SPACE = 5'b00001,
        S_ADDR  = 5'b00010,
        S_DATA  = 5'b00100,
        S_DONE  = 5'b01000,
        S_ERROR = 5'b10000
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     r_ar_addr;
    logic [AXI_LEN_W-1:0]  r_ar_len;
    logic [LENGTH_W-1:0]   r_rem;
    logic                  r_err_seen;
    logic [PERF_W-1:0]     r_clk_cnt;
    logic [PERF_W-1:0]     r_valid_cnt;

    logic                  w_desc_ready;
    logic                  w_ar_valid;
    logic                  w_r_ready;
    logic                  w_fifo_wr_en;
    logic [DATA_W-1:0]     w_fifo_wr_data;
    logic                  w_accept;
    logic [LENGTH_W-1:0]   w_nb;
    logic [LENGTH_W-1:0]   w_burst_nb;
    logic                  w_space_ok;
    logic                  w_beat_bad;

    assign w_accept   = bus.desc_valid & w_desc_ready;
    assign w_nb       = (r_rem >= LENGTH_W'(C_MAXB)) ? LENGTH_W'(C_MAXB) : r_rem;
    assign w_burst_nb = LENGTH_W'(r_ar_len) + LENGTH_W'(1);
    assign w_space_ok = C_CMP_W'(bus.fifo_space) >= C_CMP_W'(w_nb);
    assign w_beat_bad = (r_state == S_DATA) & bus.r_valid & (bus.r_resp != C_OKAY);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_desc_ready   = 1'b0;
        w_ar_valid     = 1'b0;
        w_r_ready      = 1'b0;
        w_fifo_wr_en   = 1'b0;
        w_fifo_wr_data = '0;
        o_rd_done      = 1'b0;
        o_rd_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // held low during reset so every output reads 0 while reset_n is low
                w_desc_ready = reset_n;
                if (bus.desc_valid)
                    w_next = (bus.desc_length == '0) ? S_DONE : S_SPACE;
            end
            S_SPACE: if (w_space_ok) w_next = S_ADDR;
            S_ADDR: begin
                w_ar_valid = 1'b1;
                if (bus.ar_ready) w_next = S_DATA;
            end
            S_DATA: begin
                w_r_ready      = 1'b1;
                w_fifo_wr_en   = bus.r_valid & (bus.r_resp == C_OKAY);
                w_fifo_wr_data = bus.r_data;
                if (bus.r_valid && bus.r_last) begin
                    if (r_err_seen || w_beat_bad) w_next = S_ERROR;
                    else if (r_rem != '0)         w_next = S_SPACE;
                    else                          w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_rd_done = 1'b1;
                w_next    = S_IDLE;
            end
            S_ERROR: begin
                o_rd_err  = 1'b1;
                w_r_ready = 1'b1;
                if (i_err_clear) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_ar_addr   <= '0;
            r_ar_len    <= '0;
            r_rem       <= '0;
            r_err_seen  <= 1'b0;
            r_clk_cnt   <= '0;
            r_valid_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_addr      <= bus.desc_src_addr;
                r_rem       <= bus.desc_length;
                r_err_seen  <= 1'b0;
                r_clk_cnt   <= '0;
                r_valid_cnt <= '0;
            end else begin
                if (r_state != S_IDLE)
                    r_clk_cnt <= r_clk_cnt + PERF_W'(1);
                if (bus.r_valid && w_r_ready)
                    r_valid_cnt <= r_valid_cnt + PERF_W'(1);
            end
            if (r_state == S_SPACE && w_space_ok) begin
                r_ar_addr <= r_addr;
                r_ar_len  <= AXI_LEN_W'(w_nb - LENGTH_W'(1));
            end
            if (r_state == S_ADDR && bus.ar_ready) begin
                r_rem  <= r_rem - w_burst_nb;
                r_addr <= r_addr + (ADDR_W'(w_burst_nb) << C_SIZE);
            end
            if (w_beat_bad)
                r_err_seen <= 1'b1;
            else if (r_state == S_ERROR && i_err_clear)
                r_err_seen <= 1'b0;
        end
    end

    assign bus.desc_ready   = w_desc_ready;
    assign bus.ar_valid     = w_ar_valid;
    assign bus.ar_addr      = r_ar_addr;
    assign bus.ar_len       = r_ar_len;
    assign bus.ar_size      = 3'(C_SIZE);
    assign bus.ar_burst     = C_INCR;
    assign bus.r_ready      = w_r_ready;
    assign bus.fifo_wr_en   = w_fifo_wr_en;
    assign bus.fifo_wr_data = w_fifo_wr_data;
    assign o_rd_state       = r_state;
    assign o_rd_clk_cnt     = r_clk_cnt;
    assign o_rd_valid_cnt   = r_valid_cnt;
endmodule
`default_nettype wire

// File: tb/tb_read_src_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_src_fsm
// Purpose  : Directed self-checking bench for read_src_fsm with an AXI slave model.
// Revision : 1.0
// ============================================================================
module tb_read_src_fsm;
    localparam int DATA_W = 512, ADDR_W = 64, LENGTH_W = 24, AXI_LEN_W = 8;
    localparam int SPACE_W = 10, PERF_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              err_clear = 1'b0;
    logic              rd_done, rd_err;
    logic [4:0]        rd_state;
    logic [PERF_W-1:0] clk_cnt, valid_cnt;

    read_src_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LENGTH_W(LENGTH_W),
                  .AXI_LEN_W(AXI_LEN_W), .SPACE_W(SPACE_W)) bus ();

    read_src_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LENGTH_W(LENGTH_W),
                   .AXI_LEN_W(AXI_LEN_W), .SPACE_W(SPACE_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .i_err_clear(err_clear),
        .o_rd_done(rd_done), .o_rd_err(rd_err), .o_rd_state(rd_state),
        .o_rd_clk_cnt(clk_cnt), .o_rd_valid_cnt(valid_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int ar_delay = 0, err_beat = -1, beat_id = 0;
    int ar_hs = 0, ar_unstable = 0, ar_valid_cyc = 0, done_cnt = 0;
    logic [ADDR_W-1:0] ar_addr_q[$];
    int                ar_len_q[$];
    int                push_q[$];

    // AXI slave: drives on the falling edge, one beat per cycle after the AR handshake
    initial begin
        logic [ADDR_W-1:0]    a;
        logic [AXI_LEN_W-1:0] l;
        bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0;
        bus.r_resp = 2'b00; bus.r_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && bus.ar_valid) begin
                a = bus.ar_addr; l = bus.ar_len;
                ar_addr_q.push_back(a); ar_len_q.push_back(int'(l));
                for (int n = 0; n < ar_delay; n++) begin
                    @(negedge clk);
                    if (!bus.ar_valid || bus.ar_addr !== a || bus.ar_len !== l) ar_unstable++;
                end
                bus.ar_ready = 1'b1; ar_hs++;
                @(negedge clk);
                bus.ar_ready = 1'b0;
                if (bus.ar_valid) ar_unstable++;
                for (int b = 0; b <= int'(l) && reset_n; b++) begin
                    bus.r_valid = 1'b1;
                    bus.r_data  = {16{beat_id}};
                    bus.r_resp  = (err_beat >= 0 && b >= err_beat) ? 2'b10 : 2'b00;
                    bus.r_last  = (b == int'(l));
                    beat_id++;
                    @(negedge clk);
                end
                bus.r_valid = 1'b0; bus.r_last = 1'b0; bus.r_resp = 2'b00;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #2;
            if (bus.fifo_wr_en) push_q.push_back(int'(bus.fifo_wr_data[31:0]));
            if (bus.ar_valid)   ar_valid_cyc++;
            if (rd_done)        done_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #2; end
    endtask

    task automatic clear_logs();
        ar_addr_q.delete(); ar_len_q.delete(); push_q.delete();
        ar_hs = 0; ar_unstable = 0; ar_valid_cyc = 0; done_cnt = 0;
    endtask

    task automatic send_desc(input logic [ADDR_W-1:0] addr, input int len);
        int k = 0;
        bus.desc_valid = 1'b1; bus.desc_src_addr = addr; bus.desc_length = LENGTH_W'(len);
        while (!bus.desc_ready && k < 50) begin step(1); k++; end
        n_checks++;
        if (k == 50) begin n_fail++; $display("FAIL desc_accept: desc_ready never rose"); end
        step(1);
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!rd_done && !rd_err && k < 5000) begin step(1); k++; end
        n_checks++;
        if (k == 5000) begin n_fail++; $display("FAIL end_timeout: no rd_done/rd_err within bound"); end
        step(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; step(3);
        n_checks++;
        if ({rd_state, bus.desc_ready, bus.ar_valid, bus.r_ready, bus.fifo_wr_en, rd_done, rd_err} !== 11'd0) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 0",
                {rd_state, bus.desc_ready, bus.ar_valid, bus.r_ready, bus.fifo_wr_en, rd_done, rd_err});
        end
        n_checks++;
        if (bus.ar_addr !== '0 || bus.ar_len !== '0 || clk_cnt !== '0 || valid_cnt !== '0) begin
            n_fail++; $display("FAIL reset_regs: addr %0h len %0d clk %0d val %0d expected all 0",
                bus.ar_addr, bus.ar_len, clk_cnt, valid_cnt);
        end
        n_checks++;
        if (bus.ar_size !== 3'd6 || bus.ar_burst !== 2'b01) begin
            n_fail++; $display("FAIL ar_const: size %0d burst %0d expected 6/1", bus.ar_size, bus.ar_burst);
        end
        reset_n = 1'b1; step(1);
        n_checks++;
        if (bus.desc_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", bus.desc_ready); end
    endtask

    task automatic test_single();
        int base;
        clear_logs(); base = beat_id;
        send_desc(64'h1000, 1); wait_end();
        n_checks++;
        if (ar_hs != 1 || ar_addr_q[0] !== 64'h1000 || ar_len_q[0] != 0) begin
            n_fail++; $display("FAIL single_ar: hs %0d addr %0h len %0d expected 1/1000/0", ar_hs, ar_addr_q[0], ar_len_q[0]);
        end
        n_checks++;
        if (push_q.size() != 1 || push_q[0] != base) begin
            n_fail++; $display("FAIL single_push: n %0d expected 1", push_q.size());
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL single_done: got %0d expected 1", done_cnt); end
        n_checks++;
        if (clk_cnt !== 32'd4 || valid_cnt !== 32'd1) begin
            n_fail++; $display("FAIL single_perf: clk %0d val %0d expected 4/1", clk_cnt, valid_cnt);
        end
    endtask

    task automatic test_multi_burst();
        logic [ADDR_W-1:0] exp_a[3] = '{64'h0, 64'h4000, 64'h8000};
        int exp_l[3] = '{255, 255, 87};
        int base, bad = 0;
        clear_logs(); base = beat_id;
        send_desc(64'h0, 600); wait_end();
        n_checks++;
        if (ar_hs != 3) begin n_fail++; $display("FAIL multi_ar_count: got %0d expected 3", ar_hs); end
        for (int i = 0; i < 3 && i < ar_addr_q.size(); i++) begin
            n_checks++;
            if (ar_addr_q[i] !== exp_a[i] || ar_len_q[i] != exp_l[i]) begin
                n_fail++; $display("FAIL multi_ar%0d: addr %0h len %0d expected %0h/%0d",
                    i, ar_addr_q[i], ar_len_q[i], exp_a[i], exp_l[i]);
            end
        end
        for (int i = 0; i < push_q.size(); i++) if (push_q[i] != base + i) bad++;
        n_checks++;
        if (push_q.size() != 600 || bad != 0) begin
            n_fail++; $display("FAIL multi_push: n %0d bad %0d expected 600/0", push_q.size(), bad);
        end
        n_checks++;
        if (done_cnt != 1 || valid_cnt !== 32'd600) begin
            n_fail++; $display("FAIL multi_done: done %0d val %0d expected 1/600", done_cnt, valid_cnt);
        end
    endtask

    task automatic test_fifo_space();
        clear_logs();
        bus.fifo_space = 10'd100;
        send_desc(64'h20000, 256); step(20);
        n_checks++;
        if (ar_valid_cyc != 0 || rd_state !== 5'b00001) begin
            n_fail++; $display("FAIL space_wait: ar cycles %0d state %b expected 0/00001", ar_valid_cyc, rd_state);
        end
        bus.fifo_space = 10'd300; wait_end();
        n_checks++;
        if (ar_hs != 1 || ar_len_q[0] != 255 || ar_addr_q[0] !== 64'h20000 || push_q.size() != 256) begin
            n_fail++; $display("FAIL space_issue: hs %0d len %0d pushes %0d expected 1/255/256",
                ar_hs, ar_len_q[0], push_q.size());
        end
        bus.fifo_space = 10'd512;
    endtask

    task automatic test_ar_backpressure();
        clear_logs(); ar_delay = 10;
        send_desc(64'h2000, 4); wait_end();
        ar_delay = 0;
        n_checks++;
        if (ar_unstable != 0 || ar_hs != 1 || ar_valid_cyc != 11) begin
            n_fail++; $display("FAIL ar_stall: unstable %0d hs %0d valid cycles %0d expected 0/1/11",
                ar_unstable, ar_hs, ar_valid_cyc);
        end
        n_checks++;
        if (push_q.size() != 4 || done_cnt != 1) begin
            n_fail++; $display("FAIL ar_stall_data: pushes %0d done %0d expected 4/1", push_q.size(), done_cnt);
        end
    endtask

    task automatic test_slverr();
        int base;
        clear_logs(); base = beat_id; err_beat = 2;
        send_desc(64'h3000, 8); wait_end();
        err_beat = -1;
        n_checks++;
        if (push_q.size() != 2 || push_q[0] != base || push_q[1] != base + 1) begin
            n_fail++; $display("FAIL err_push: n %0d expected 2", push_q.size());
        end
        step(5);
        n_checks++;
        if (rd_err !== 1'b1 || rd_state !== 5'b10000 || done_cnt != 0 || bus.desc_ready !== 1'b0) begin
            n_fail++; $display("FAIL err_hold: err %b state %b done %0d expected 1/10000/0", rd_err, rd_state, done_cnt);
        end
        n_checks++;
        if (valid_cnt !== 32'd8) begin n_fail++; $display("FAIL err_valid_cnt: got %0d expected 8", valid_cnt); end
        err_clear = 1'b1; step(1); err_clear = 1'b0;
        n_checks++;
        if (rd_err !== 1'b0 || rd_state !== 5'b00000 || bus.desc_ready !== 1'b1) begin
            n_fail++; $display("FAIL err_clear: err %b state %b ready %b expected 0/00000/1", rd_err, rd_state, bus.desc_ready);
        end
        clear_logs(); send_desc(64'h4000, 2); wait_end();
        n_checks++;
        if (done_cnt != 1 || push_q.size() != 2) begin
            n_fail++; $display("FAIL err_recover: done %0d pushes %0d expected 1/2", done_cnt, push_q.size());
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        bus.desc_valid = 1'b1; bus.desc_src_addr = 64'h7000; bus.desc_length = '0;
        step(1);
        bus.desc_valid = 1'b0;
        n_checks++;
        if (rd_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", rd_done); end
        step(1);
        n_checks++;
        if (rd_done !== 1'b0 || rd_state !== 5'b00000 || ar_valid_cyc != 0 || clk_cnt !== 32'd1) begin
            n_fail++; $display("FAIL zero_after: done %b state %b ar %0d clk %0d expected 0/00000/0/1",
                rd_done, rd_state, ar_valid_cyc, clk_cnt);
        end
    endtask

    task automatic test_reset_mid_data();
        int k = 0;
        clear_logs();
        send_desc(64'h5000, 8);
        while (!(rd_state === 5'b00100 && push_q.size() >= 3) && k < 200) begin step(1); k++; end
        n_checks++;
        if (k == 200) begin n_fail++; $display("FAIL mid_data_reach: state %b", rd_state); end
        reset_n = 1'b0; step(1);
        n_checks++;
        if ({rd_state, bus.desc_ready, bus.ar_valid, bus.r_ready, bus.fifo_wr_en, rd_done, rd_err} !== 11'd0
            || clk_cnt !== '0 || valid_cnt !== '0 || bus.ar_addr !== '0 || bus.fifo_wr_data !== '0) begin
            n_fail++; $display("FAIL mid_reset: state %b ready %b rready %b clk %0d val %0d expected all 0",
                rd_state, bus.desc_ready, bus.r_ready, clk_cnt, valid_cnt);
        end
        step(1); reset_n = 1'b1; step(1);
        n_checks++;
        if (bus.desc_ready !== 1'b1 || rd_state !== 5'b00000) begin
            n_fail++; $display("FAIL post_reset: ready %b state %b expected 1/00000", bus.desc_ready, rd_state);
        end
    endtask

    initial begin
        bus.desc_valid = 1'b0; bus.desc_src_addr = '0; bus.desc_length = '0;
        bus.fifo_space = 10'd512;
        test_reset();
        test_single();
        test_multi_burst();
        test_fifo_space();
        test_ar_backpressure();
        test_slverr();
        test_zero_len();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
